// File: rtl/pkt_drop_avlstrm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : pkt_drop_avlstrm
// Purpose : Packet-granular admission stage in front of a stream FIFO. At
//           every start-of-packet the downstream almost_full is sampled and
//           the whole packet is either forwarded through one output register
//           or consumed and discarded. Forwarded, dropped and malformed
//           packets are counted.
// Revision: 1.0 - initial release
// ============================================================================
module pkt_drop_avlstrm #(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  // upstream stream
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  output logic                   in_ready,
  output logic                   in_almost_full,
  // downstream stream (FIFO input)
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  input  logic                   out_ready,
  input  logic                   out_almost_full,
  // statistics
  output logic [31:0]            pkt_fwd,
  output logic [31:0]            pkt_drop,
  output logic [31:0]            pkt_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [DATA_WIDTH-1:0]  r_out_data;
  logic [EMPTY_WIDTH-1:0] r_out_empty;
  logic                   r_out_valid;
  logic                   r_out_sop;
  logic                   r_out_eop;

  logic [31:0]            r_pkt_fwd;
  logic [31:0]            r_pkt_drop;
  logic [31:0]            r_pkt_err;

  logic                   w_out_free;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_load;
  logic                   w_inc_fwd;
  logic                   w_inc_drop;
  logic                   w_inc_err;

  // Ready generation, admission decision and next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_inc_fwd   = 1'b0;
    w_inc_drop  = 1'b0;
    w_inc_err   = 1'b0;
    w_out_free  = !r_out_valid || out_ready;

    // While dropping, non-sop beats are sunk unconditionally. A sop arriving
    // mid-drop may be forwarded, so it must also wait for a free output
    // register to avoid overwriting a beat the FIFO has not taken yet.
    if (r_state == S_DROP) begin
      w_in_ready = w_out_free || !in_sop;
    end else begin
      w_in_ready = w_out_free;
    end
    if (!Rst_n) begin
      w_in_ready = 1'b0;
    end

    w_accept = in_valid && w_in_ready;

    if (w_accept) begin
      if (in_sop) begin
        // A sop outside IDLE means the previous packet lost its eop
        if (r_state != S_IDLE) begin
          w_inc_err = 1'b1;
        end
        if (out_almost_full) begin
          w_inc_drop  = 1'b1;
          w_state_nxt = in_eop ? S_IDLE : S_DROP;
        end else begin
          w_inc_fwd   = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = in_eop ? S_IDLE : S_PASS;
        end
      end else begin
        case (r_state)
          S_PASS: begin
            w_load = 1'b1;
            if (in_eop) begin
              w_state_nxt = S_IDLE;
            end
          end
          S_DROP: begin
            if (in_eop) begin
              w_state_nxt = S_IDLE;
            end
          end
          default: begin
            // Orphan beat with no packet open: discard and flag it
            w_inc_err = 1'b1;
          end
        endcase
      end
    end
  end

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register control: load on forward, clear on drain without reload
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_sop   <= in_sop;
      r_out_eop   <= in_eop;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
    end
  end

  // Output payload: qualified by out_valid, so it needs no reset
  always_ff @(posedge Clk) begin
    if (w_load) begin
      r_out_data  <= in_data;
      r_out_empty <= in_empty;
    end
  end

  // Statistics counters, wrapping modulo 2^32
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pkt_fwd  <= 32'd0;
      r_pkt_drop <= 32'd0;
      r_pkt_err  <= 32'd0;
    end else begin
      if (w_inc_fwd) begin
        r_pkt_fwd <= r_pkt_fwd + 32'd1;
      end
      if (w_inc_drop) begin
        r_pkt_drop <= r_pkt_drop + 32'd1;
      end
      if (w_inc_err) begin
        r_pkt_err <= r_pkt_err + 32'd1;
      end
    end
  end

  assign in_ready       = w_in_ready;
  assign in_almost_full = 1'b0;

  assign out_data       = r_out_data;
  assign out_valid      = r_out_valid;
  assign out_sop        = r_out_sop;
  assign out_eop        = r_out_eop;
  assign out_empty      = r_out_empty;

  assign pkt_fwd        = r_pkt_fwd;
  assign pkt_drop       = r_pkt_drop;
  assign pkt_err        = r_pkt_err;

endmodule
`default_nettype wire
